// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: accepts a WIDTH-bit word over valid/ready and
// emits it one bit per shift_en slot, reloading on the last slot with no bubble.
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             last_bit
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_shreg;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_valid;

    logic               w_last;
    logic               w_accept;
    logic               w_consume;

    assign w_last     = (r_state == SHIFT) && (r_cnt == CNT_W'(WIDTH - 1));
    // Gated by reset so no word can be taken while reset is being applied
    assign load_ready = reset && ((r_state == IDLE) || (w_last && shift_en));
    assign w_accept   = load_valid && load_ready;
    assign w_consume  = (r_state == SHIFT) && shift_en;

    // shreg is zero whenever idle, so the output bit is 0 outside a word
    assign serial_out   = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
    assign serial_valid = r_valid;
    assign last_bit     = w_last;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_state <= SHIFT;
            r_shreg <= load_data;
            r_cnt   <= '0;
            r_valid <= 1'b1;
        end else if (w_consume) begin
            if (w_last) begin
                r_state <= IDLE;
                r_shreg <= '0;
                r_cnt   <= '0;
                r_valid <= 1'b0;
            end else begin
                r_shreg <= MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0}
                                     : {1'b0, r_shreg[WIDTH-1:1]};
                r_cnt   <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances share stimulus and
// are compared each cycle against a word/position reference model.
module tb_piso_serializer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] load_data;
    logic         load_valid;
    logic         shift_en;

    logic         ready_m, out_m, valid_m, last_m;
    logic         ready_l, out_l, valid_l, last_l;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: word in flight and how many bits have been consumed
    bit           m_busy = 1'b0;
    int           m_pos  = 0;
    logic [W-1:0] m_word = '0;

    logic [W-1:0] q[$];
    logic [W-1:0] dsr = '0;
    bit           lv_hold = 1'b0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .reset(reset), .load_data(load_data), .load_valid(load_valid),
        .load_ready(ready_m), .shift_en(shift_en), .serial_out(out_m),
        .serial_valid(valid_m), .last_bit(last_m)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .load_data(load_data), .load_valid(load_valid),
        .load_ready(ready_l), .shift_en(shift_en), .serial_out(out_l),
        .serial_valid(valid_l), .last_bit(last_l)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic exp_last, exp_msb, exp_lsb;
        exp_last = m_busy && (m_pos == W - 1);
        exp_msb  = m_busy ? m_word[W-1-m_pos] : 1'b0;
        exp_lsb  = m_busy ? m_word[m_pos]     : 1'b0;
        check("valid_msb", 32'(valid_m), 32'(m_busy));
        check("out_msb",   32'(out_m),   32'(exp_msb));
        check("last_msb",  32'(last_m),  32'(exp_last));
        check("valid_lsb", 32'(valid_l), 32'(m_busy));
        check("out_lsb",   32'(out_l),   32'(exp_lsb));
        check("last_lsb",  32'(last_l),  32'(exp_last));
    endtask

    task automatic cycle(input bit rst_i, input bit se_i, input bit gate);
        bit           exp_ready, acc, cons;
        logic         so;
        logic [W-1:0] ld;
        reset      = rst_i;
        shift_en   = se_i;
        load_valid = (gate || lv_hold) && (q.size() > 0);
        load_data  = load_valid ? q[0] : W'($urandom);
        #2;
        exp_ready = rst_i && (!m_busy || ((m_pos == W - 1) && se_i));
        check("ready_msb", 32'(ready_m), 32'(exp_ready));
        check("ready_lsb", 32'(ready_l), 32'(exp_ready));
        so   = out_m;
        ld   = load_data;
        acc  = load_valid && exp_ready;
        cons = rst_i && m_busy && se_i;
        @(posedge clk);
        lv_hold = load_valid && !acc;
        if (!rst_i) begin
            m_busy = 1'b0;
            m_pos  = 0;
        end else begin
            if (cons) begin
                dsr = {dsr[W-2:0], so};
                m_pos++;
                if (m_pos == W) begin
                    // Downstream left-shift register must now hold the full word
                    check("downstream", 32'(dsr), 32'(m_word));
                    m_busy = 1'b0;
                end
            end
            if (acc) begin
                m_word = ld;
                m_pos  = 0;
                m_busy = 1'b1;
                void'(q.pop_front());
            end
        end
        #1;
        check_outputs();
    endtask

    initial begin
        reset      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        shift_en   = 1'b0;

        // Reset held two cycles, then release
        repeat (2) cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);

        // Single word, free-running shift
        q.push_back(4'b1011);
        repeat (6) cycle(1'b1, 1'b1, 1'b1);

        // Back-to-back words
        q.push_back(4'b1011);
        q.push_back(4'b0110);
        repeat (10) cycle(1'b1, 1'b1, 1'b1);

        // Stall for three slots after the first bit appears
        q.push_back(4'b1001);
        cycle(1'b1, 1'b1, 1'b1);
        repeat (3) cycle(1'b1, 1'b0, 1'b1);
        repeat (5) cycle(1'b1, 1'b1, 1'b1);

        // Reset during the second bit, then a clean word
        q.push_back(4'b1111);
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        q.push_back(4'b0001);
        repeat (6) cycle(1'b1, 1'b1, 1'b1);

        // Second word offered mid-word must wait for load_ready
        q.push_back(4'b0011);
        cycle(1'b1, 1'b1, 1'b1);
        q.push_back(4'b0101);
        repeat (12) cycle(1'b1, 1'b1, 1'b1);

        for (int i = 0; i < 400; i++) begin
            if (q.size() < 2 && $urandom_range(0, 2) == 0) q.push_back(W'($urandom));
            cycle($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
